sim_store_monitor: RTL and testbench

- Parametrised, self-checking store-bus monitor for the pipelined RISC-V top level. Snoops the memory-stage store bus (memwriteM, dataAdrM, writedataM) of top.
- Records a rolling log of stores and counts cycles since reset release.
- Declares PASS, FAIL or TIMEOUT from a signature store, replacing the fixed-delay, print-one-value end-of-run check in benches.
- Synthesisable, so it can also sit in FPGA bring-up builds driving status LEDs.

---
 rtl/sim_store_monitor.sv | 138 +++++++++++++
 tb/tb_sim_store_monitor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sim_store_monitor.sv
// ---------------------------------------------------------------------------
// sim_store_monitor: snoops the M-stage store bus, keeps a rolling store log
// and declares PASS / FAIL / TIMEOUT from a signature store.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sim_store_monitor #(
  parameter int WIDTH          = 32,
  parameter int SIG_ADDR       = 100,
  parameter int PASS_VALUE     = 25,
  parameter int TIMEOUT_CYCLES = 50,
  parameter int LOG_DEPTH      = 8,
  parameter int CNT_W          = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           memwriteM,
  input  logic [WIDTH-1:0]               dataAdrM,
  input  logic [WIDTH-1:0]               writedataM,
  input  logic [$clog2(LOG_DEPTH)-1:0]   log_rd_idx,
  output logic [WIDTH-1:0]               log_rd_addr,
  output logic [WIDTH-1:0]               log_rd_data,
  output logic [$clog2(LOG_DEPTH):0]     log_count,
  output logic                           log_overflow,
  output logic [CNT_W-1:0]               store_count,
  output logic [CNT_W-1:0]               cycle_count,
  output logic                           done,
  output logic                           pass,
  output logic                           fail,
  output logic                           timeout
);

  localparam int IW = $clog2(LOG_DEPTH);
  localparam logic [WIDTH-1:0] C_SIG_ADDR   = WIDTH'(SIG_ADDR);
  localparam logic [WIDTH-1:0] C_PASS_VALUE = WIDTH'(PASS_VALUE);
  localparam logic [IW:0]      C_DEPTH      = (IW+1)'(LOG_DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;
  localparam logic [31:0]      C_TO_LAST    = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_PASS    = 2'd1,
    S_FAIL    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] store_q, store_d;
  logic [IW-1:0]    wr_q, wr_d;
  logic [IW-1:0]    old_q, old_d;
  logic [IW:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             log_we;
  logic             to_hit;
  logic [IW-1:0]    rd_slot;

  logic [WIDTH-1:0] addr_mem [LOG_DEPTH];
  logic [WIDTH-1:0] data_mem [LOG_DEPTH];

  // Compare in 32 bits so a TIMEOUT_CYCLES wider than CNT_W is never aliased.
  assign to_hit = (32'(cycle_q) == C_TO_LAST);

  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    store_d = store_q;
    wr_d    = wr_q;
    old_d   = old_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    log_we  = 1'b0;
    if (state_q == S_RUN) begin
      if (cycle_q != C_CNT_MAX) cycle_d = cycle_q + CNT_W'(1);
      if (memwriteM) begin
        log_we = 1'b1;
        wr_d   = wr_q + IW'(1);
        if (store_q != C_CNT_MAX) store_d = store_q + CNT_W'(1);
        if (cnt_q == C_DEPTH) begin
          old_d = old_q + IW'(1);
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + (IW+1)'(1);
        end
        if (dataAdrM == C_SIG_ADDR) begin
          state_d = (writedataM == C_PASS_VALUE) ? S_PASS : S_FAIL;
        end else if (to_hit) begin
          state_d = S_TIMEOUT;
        end
      end else if (to_hit) begin
        state_d = S_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      cycle_q <= '0;
      store_q <= '0;
      wr_q    <= '0;
      old_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      store_q <= store_d;
      wr_q    <= wr_d;
      old_q   <= old_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Log storage needs no reset; unread slots are don't-care.
  always_ff @(posedge clock) begin
    if (log_we) begin
      addr_mem[wr_q] <= dataAdrM;
      data_mem[wr_q] <= writedataM;
    end
  end

  assign rd_slot      = old_q + log_rd_idx;
  assign log_rd_addr  = addr_mem[rd_slot];
  assign log_rd_data  = data_mem[rd_slot];
  assign log_count    = cnt_q;
  assign log_overflow = ovf_q;
  assign store_count  = store_q;
  assign cycle_count  = cycle_q;
  assign done         = (state_q != S_RUN);
  assign pass         = (state_q == S_PASS);
  assign fail         = (state_q == S_FAIL) || (state_q == S_TIMEOUT);
  assign timeout      = (state_q == S_TIMEOUT);

endmodule

`default_nettype wire

// File: tb/tb_sim_store_monitor.sv
// ---------------------------------------------------------------------------
// tb_sim_store_monitor: directed bench for sim_store_monitor.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sim_store_monitor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        memwriteM = 1'b0;
  logic [31:0] dataAdrM = '0;
  logic [31:0] writedataM = '0;
  logic [2:0]  log_rd_idx = '0;
  logic [31:0] log_rd_addr, log_rd_data;
  logic [3:0]  log_count;
  logic        log_overflow;
  logic [15:0] store_count, cycle_count;
  logic        done, pass, fail, timeout;

  logic        s_memwriteM = 1'b0;
  logic [31:0] s_dataAdrM = '0;
  logic [31:0] s_writedataM = '0;
  logic [2:0]  s_log_rd_idx = '0;
  logic [31:0] s_log_rd_addr, s_log_rd_data;
  logic [3:0]  s_log_count;
  logic        s_log_overflow;
  logic [3:0]  s_store_count, s_cycle_count;
  logic        s_done, s_pass, s_fail, s_timeout;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  sim_store_monitor u_dut (
    .clock(clock), .reset(reset), .memwriteM(memwriteM), .dataAdrM(dataAdrM),
    .writedataM(writedataM), .log_rd_idx(log_rd_idx), .log_rd_addr(log_rd_addr),
    .log_rd_data(log_rd_data), .log_count(log_count), .log_overflow(log_overflow),
    .store_count(store_count), .cycle_count(cycle_count), .done(done),
    .pass(pass), .fail(fail), .timeout(timeout)
  );

  sim_store_monitor #(.CNT_W(4), .TIMEOUT_CYCLES(200)) u_sat (
    .clock(clock), .reset(reset), .memwriteM(s_memwriteM), .dataAdrM(s_dataAdrM),
    .writedataM(s_writedataM), .log_rd_idx(s_log_rd_idx), .log_rd_addr(s_log_rd_addr),
    .log_rd_data(s_log_rd_data), .log_count(s_log_count), .log_overflow(s_log_overflow),
    .store_count(s_store_count), .cycle_count(s_cycle_count), .done(s_done),
    .pass(s_pass), .fail(s_fail), .timeout(s_timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a store for the next rising edge (called at a falling edge).
  task automatic put(input logic [31:0] a, input logic [31:0] d);
    memwriteM  = 1'b1;
    dataAdrM   = a;
    writedataM = d;
    @(negedge clock);
  endtask

  task automatic idle();
    memwriteM = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_reset();
    memwriteM = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("rst_done", done, 1'b0);
    check("rst_flags", {pass, fail, timeout, log_overflow}, 4'b0000);
    check("rst_counts", {store_count, cycle_count, log_count}, 36'd0);
    reset = 1'b0;

    // Pass path
    put(32'h10, 32'd3);
    put(32'h14, 32'd7);
    check("pass_not_yet", done, 1'b0);
    put(32'd100, 32'd25);
    memwriteM = 1'b0;
    check("pass_done", {done, pass, fail, timeout}, 4'b1100);
    check("pass_store_cnt", store_count, 16'd3);
    check("pass_log_cnt", log_count, 4'd3);
    log_rd_idx = 3'd0; #1;
    check("pass_idx0", {log_rd_addr, log_rd_data}, {32'h10, 32'd3});
    log_rd_idx = 3'd2; #1;
    check("pass_idx2", {log_rd_addr, log_rd_data}, {32'd100, 32'd25});
    put(32'h20, 32'd1);
    memwriteM = 1'b0;
    check("pass_frozen", {store_count, log_count}, {16'd3, 4'd3});

    // Fail path
    do_reset();
    put(32'd100, 32'd24);
    check("fail_flags", {done, pass, fail, timeout}, 4'b1010);
    put(32'd100, 32'd25);
    memwriteM = 1'b0;
    check("fail_ignored", {store_count, pass}, {16'd1, 1'b0});

    // Timeout with no signature
    do_reset();
    repeat (49) idle();
    check("to_49", {done, cycle_count}, {1'b0, 16'd49});
    idle();
    check("to_50", {done, pass, fail, timeout}, 4'b1011);
    check("to_cyc50", cycle_count, 16'd50);
    idle();
    check("to_frozen", cycle_count, 16'd50);

    // Signature on the timeout edge wins
    do_reset();
    repeat (49) idle();
    put(32'd100, 32'd25);
    memwriteM = 1'b0;
    check("race_flags", {done, pass, fail, timeout}, 4'b1100);
    check("race_cyc", cycle_count, 16'd50);

    // Log wrap
    do_reset();
    for (int i = 0; i < 8; i++) put(32'(4 * i), 32'(i));
    check("wrap_full_noovf", {log_count, log_overflow}, {4'd8, 1'b0});
    for (int i = 8; i < 10; i++) put(32'(4 * i), 32'(i));
    memwriteM = 1'b0;
    check("wrap_cnt_ovf", {log_count, log_overflow}, {4'd8, 1'b1});
    log_rd_idx = 3'd0; #1;
    check("wrap_idx0", {log_rd_addr, log_rd_data}, {32'd8, 32'd2});
    log_rd_idx = 3'd7; #1;
    check("wrap_idx7", {log_rd_addr, log_rd_data}, {32'd36, 32'd9});
    check("wrap_stores", {store_count, done}, {16'd10, 1'b0});

    // Async reset mid-run
    do_reset();
    for (int i = 0; i < 5; i++) put(32'h40 + 32'(i), 32'(i));
    memwriteM = 1'b0;
    check("ar_before", store_count, 16'd5);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("ar_cleared", {store_count, cycle_count, log_count}, 36'd0);
    check("ar_flags", {done, pass, fail, timeout, log_overflow}, 5'd0);
    @(negedge clock);
    reset = 1'b0;
    put(32'd100, 32'd25);
    memwriteM = 1'b0;
    check("ar_after", {store_count, log_count, pass}, {16'd1, 4'd1, 1'b1});

    // Counter saturation on the narrow-counter instance
    do_reset();
    for (int i = 0; i < 20; i++) begin
      s_memwriteM = 1'b1;
      s_dataAdrM  = 32'h80;
      s_writedataM = 32'(i);
      @(negedge clock);
    end
    s_memwriteM = 1'b0;
    check("sat_counts", {s_store_count, s_cycle_count}, {4'd15, 4'd15});
    check("sat_state", {s_done, s_log_count, s_log_overflow}, {1'b0, 4'd8, 1'b1});
    @(negedge clock);
    check("sat_hold", s_cycle_count, 4'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
